// File: rtl/boron_pkg.sv
// Shared definitions for the Boron datapath: default widths, the 4-bit
// S-box used by the key schedule, and the Add-Round-Key state encoding.
package boron_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_KEY_W      = 80;
    localparam int DEF_NUM_ROUNDS = 25;
    localparam int DEF_ROT        = 13;
    localparam int DEF_RC_MSB     = 63;

    // Boron 4-bit S-box, indexed by the input nibble.
    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
        4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ark_state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/boron_key_update.sv
// One round of the Boron key schedule, purely combinational:
// rotate left by ROT, substitute the low nibble through the S-box,
// then XOR (round+1) into the 5-bit counter field ending at RC_MSB.
// The order of the three steps is significant.
module boron_key_update
    import boron_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int ROT    = DEF_ROT,
    parameter int RC_MSB = DEF_RC_MSB
) (
    input  logic [KEY_W-1:0] key_cur,
    input  logic [4:0]       round,
    output logic [KEY_W-1:0] key_next
);

    logic [KEY_W-1:0] rot_s;
    logic [4:0]       rc_s;

    // Rotate, substitute, then fold the incremented round counter in.
    always_comb begin
        rot_s    = (key_cur << ROT) | (key_cur >> (KEY_W - ROT));
        rc_s     = round + 5'd1;
        key_next = rot_s;
        key_next[3:0] = sbox(rot_s[3:0]);
        key_next[RC_MSB -: 5] = key_next[RC_MSB -: 5] ^ rc_s;
    end

endmodule

// File: rtl/add_round_key_seq.sv
// Sequential Add-Round-Key engine for the Boron datapath.
// Holds the key schedule on chip, XORs the low DATA_W bits of the current
// round key into each accepted state beat and steps the schedule once per
// beat, for NUM_ROUNDS+1 beats per loaded key.
// Optional build macro ARK_FINAL_KEY_EN adds final_key_o, the schedule
// register exposed while done_o is high (zero otherwise).
module add_round_key_seq
    import boron_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROT        = DEF_ROT,
    parameter int RC_MSB     = DEF_RC_MSB
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              key_load_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [4:0]        round_o,
    output logic              done_o
`ifdef ARK_FINAL_KEY_EN
    ,
    output logic [KEY_W-1:0]  final_key_o
`endif
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    ark_state_e       state_r;
    logic [KEY_W-1:0] key_r;
    logic [4:0]       round_r;
    logic [KEY_W-1:0] key_next_s;
    logic             accept_s;

    boron_key_update #(
        .KEY_W  (KEY_W),
        .ROT    (ROT),
        .RC_MSB (RC_MSB)
    ) u_key_update (
        .key_cur  (key_r),
        .round    (round_r),
        .key_next (key_next_s)
    );

    // Ready only while running; a key load in the same cycle blocks the beat.
    always_comb begin
        if ((state_r == ST_RUN) && !key_load_i) begin
            in_ready_o = !out_valid_o || out_ready_i;
        end else begin
            in_ready_o = 1'b0;
        end
        accept_s = in_valid_i && in_ready_o;
    end

    // Control FSM, key schedule and registered result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            key_r       <= {KEY_W{1'b0}};
            round_r     <= 5'd0;
            out_valid_o <= 1'b0;
            data_o      <= {DATA_W{1'b0}};
            round_o     <= 5'd0;
            done_o      <= 1'b0;
        end else begin
            // Single output stage: load on accept, drain on downstream ready.
            if (accept_s) begin
                data_o      <= data_i ^ key_r[DATA_W-1:0];
                round_o     <= round_r;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end else begin
                out_valid_o <= out_valid_o;
            end

            if (key_load_i) begin
                key_r   <= key_i;
                round_r <= 5'd0;
                done_o  <= 1'b0;
                state_r <= ST_RUN;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (accept_s) begin
                            if (round_r == LAST_ROUND) begin
                                // Final key is kept in place for final_key_o.
                                state_r <= ST_DONE;
                                done_o  <= 1'b1;
                            end else begin
                                key_r   <= key_next_s;
                                round_r <= round_r + 5'd1;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_IDLE: state_r <= ST_IDLE;
                    ST_DONE: state_r <= ST_DONE;
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ARK_FINAL_KEY_EN
    // Expose the last schedule value only once all rounds are consumed.
    always_comb begin
        if (done_o) begin
            final_key_o = key_r;
        end else begin
            final_key_o = {KEY_W{1'b0}};
        end
    end
`endif

endmodule
